// File: rtl/pipeline_sequencer.sv
// Run/step/drain controller driving PC and pipeline-register enables/flushes for a 5-stage RV32I core.
// Latency: strobes are combinational from state and hazard inputs; state and counters update on the next edge.
// Backpressure: load-use stalls freeze PC/IF-ID for one cycle; debug halt freezes everything the same cycle.
module pipeline_sequencer #(
    parameter int NB_REG_ADDR  = 5,
    parameter int NB_CNT       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_step,
    input  logic                   i_halt_req,
    input  logic [6:0]             i_id_opcode,
    input  logic [NB_REG_ADDR-1:0] i_id_rs1,
    input  logic [NB_REG_ADDR-1:0] i_id_rs2,
    input  logic                   i_ex_MemRead,
    input  logic [NB_REG_ADDR-1:0] i_ex_rd,
    input  logic                   i_ex_take_branch,
    output logic                   o_pc_en,
    output logic                   o_if_id_en,
    output logic                   o_if_id_flush,
    output logic                   o_id_ex_flush,
    output logic                   o_pipe_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [NB_CNT-1:0]      o_cycle_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int              NB_DRN   = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_DRN-1:0] DRN_LOAD = NB_DRN'(DRAIN_CYCLES);
    localparam logic [NB_DRN-1:0] DRN_ONE  = NB_DRN'(1);

    logic [2:0]        state_q, state_d;
    logic [NB_DRN-1:0] drn_q, drn_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;

    logic       is_ecall;
    logic       load_use;
    logic [2:0] adv_next;

    assign is_ecall = (i_id_opcode == OPC_SYSTEM);
    assign load_use = i_ex_MemRead && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
    // After an ordinary advancing cycle RUN keeps running, STEP falls back to IDLE.
    assign adv_next = (state_q == ST_RUN) ? ST_RUN : ST_IDLE;

    // Strobe decode and next-state selection from current state and hazard inputs.
    always_comb begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_pipe_en     = 1'b0;
        state_d       = state_q;
        drn_d         = drn_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if ((state_q == ST_RUN) && i_halt_req) begin
                    // Freeze in place: nothing advances this cycle.
                    state_d = ST_IDLE;
                end else if (i_ex_take_branch) begin
                    // Wrong-path fetch squashed; this also kills an ECALL sitting in ID.
                    o_pc_en       = 1'b1;
                    o_if_id_en    = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                    o_pipe_en     = 1'b1;
                    state_d       = adv_next;
                end else if (is_ecall) begin
                    // ECALL turns into a bubble; older instructions keep draining.
                    o_id_ex_flush = 1'b1;
                    o_pipe_en     = 1'b1;
                    state_d       = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                    drn_d         = DRN_LOAD;
                end else if (load_use) begin
                    o_id_ex_flush = 1'b1;
                    o_pipe_en     = 1'b1;
                    state_d       = adv_next;
                end else begin
                    o_pc_en    = 1'b1;
                    o_if_id_en = 1'b1;
                    o_pipe_en  = 1'b1;
                    state_d    = adv_next;
                end
            end
            ST_DRAIN: begin
                o_id_ex_flush = 1'b1;
                o_pipe_en     = 1'b1;
                drn_d         = drn_q - DRN_ONE;
                if (drn_q <= DRN_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    assign o_done      = (state_q == ST_DONE);
    assign o_cycle_cnt = cnt_q;
    assign cnt_d       = cnt_q + {{(NB_CNT-1){1'b0}}, o_pipe_en};

    // State, drain counter and executed-cycle counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            drn_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run/step/drain controller for the 5-stage RV32I pipeline. Sits beside the base integer control unit and drives the enable and flush strobes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Inserts load-use bubbles and squashes wrong-path fetches on taken branches and jumps. Drains the pipeline and stops on ECALL, and lets the debug side start, freeze or single-step the core.

## Interface
- NB_REG_ADDR, 5, register address width
- NB_CNT, 32, width of the executed-cycle counter
- DRAIN_CYCLES, 3, back-end cycles run after ECALL detection before DONE
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_start  in  1  run request (level or pulse)
- i_step  in  1  single-step request pulse
- i_halt_req  in  1  debug freeze request
- i_id_opcode  in  7  opcode of the instruction in ID
- i_id_rs1  in  NB_REG_ADDR  rs1 of the instruction in ID
- i_id_rs2  in  NB_REG_ADDR  rs2 of the instruction in ID
- i_ex_MemRead  in  1  instruction in EX is a load
- i_ex_rd  in  NB_REG_ADDR  rd of the instruction in EX
- i_ex_take_branch  in  1  taken branch, JAL or JALR resolved in EX
- o_pc_en  out  1  PC load enable
- o_if_id_en  out  1  IF/ID register enable
- o_if_id_flush  out  1  IF/ID register clear (NOP)
- o_id_ex_flush  out  1  ID/EX register clear (bubble)
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers
- o_busy  out  1  state is RUN, STEP or DRAIN
- o_done  out  1  state is DONE
- o_cycle_cnt  out  NB_CNT  count of cycles with o_pipe_en=1

## Operation
- States: IDLE, RUN, STEP, DRAIN, DONE. State and counters are registered. Strobes are combinational from the state and the hazard inputs.
- IDLE (reset state): all strobes 0, and the pipeline is frozen.
  - i_start=1 -> RUN.
  - Else i_step=1 -> STEP. i_start wins when both are 1.
- RUN: the pipeline advances each cycle.
  - i_halt_req=1 -> this cycle all strobes 0, next state IDLE. The pipeline can be resumed with i_start or i_step.
  - ECALL in ID (i_id_opcode=7'b1110011) with i_ex_take_branch=0 and i_halt_req=0 -> DRAIN. The drain counter loads DRAIN_CYCLES.
- STEP: the pipeline advances exactly one cycle, then returns to IDLE. ECALL seen during STEP -> DRAIN instead of IDLE. i_halt_req is ignored in STEP.
- DRAIN: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_pipe_en=1.
  - The counter decrements each cycle; at 1 -> DONE.
  - i_halt_req, i_start and i_step are ignored.
- DONE: all strobes 0 and o_done=1. Only reset leaves DONE.
- Advancing cycle (RUN, or STEP), in priority order:
  1. Taken branch (i_ex_take_branch=1): o_pc_en=1, o_if_id_en=1, o_if_id_flush=1, o_id_ex_flush=1, o_pipe_en=1.
  2. Load-use (i_ex_MemRead=1, i_ex_rd!=0, and i_ex_rd equals i_id_rs1 or i_id_rs2): o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_pipe_en=1.
  3. Otherwise: o_pc_en=1, o_if_id_en=1, o_pipe_en=1, and both flushes are 0.
- ECALL-detection cycle: strobes are forced to the DRAIN pattern, so the ECALL becomes a bubble. This cycle is not part of the DRAIN_CYCLES count.
- o_cycle_cnt increments on every cycle with o_pipe_en=1 and wraps from 2^NB_CNT-1 to 0.

## Timing
- Reset (i_rst_n=0 at a rising edge): state=IDLE, drain counter=0, o_cycle_cnt=0. All strobes 0, o_busy=0, o_done=0.
- Reset mid-operation, including in DRAIN or DONE: same values on the next edge. A partially drained pipeline is abandoned.
- i_start sampled in IDLE at edge N: first advancing cycle is N+1.
- i_step pulse at edge N: exactly one cycle with o_pipe_en=1 (N+1). Strobes are 0 again from N+2. A held i_step gives one step per two cycles.
- i_halt_req high during a RUN cycle: that same cycle has no enables, and the pipeline does not advance.
- A load-use stall lasts exactly one cycle. Next cycle the load is in MEM and the hazard clears.
- Branch flush: a single cycle; fetch resumes at the target on the next cycle.
- ECALL detected at cycle N: cycles N..N+DRAIN_CYCLES have o_pipe_en=1 with PC frozen. o_done=1 from cycle N+DRAIN_CYCLES+1.
- ECALL in ID together with a taken branch in EX: the branch wins, ECALL is squashed, and there is no DRAIN.

## Test plan
- Reset, then i_start=1 for one cycle with no hazards, 10 cycles -> o_pc_en=o_if_id_en=o_pipe_en=1 each cycle, o_cycle_cnt=10.
- RUN, i_ex_MemRead=1, i_ex_rd=5, i_id_rs2=5 for one cycle -> that cycle o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_pipe_en=1. Repeat with i_ex_rd=0 -> no stall.
- RUN, i_ex_take_branch=1 with a load-use match in the same cycle -> o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1.
- RUN, i_id_opcode=7'b1110011 at cycle N (DRAIN_CYCLES=3) -> o_pc_en=0 for N..N+3, o_pipe_en=1 for N..N+3, o_done=1 from N+4. i_start at N+6 has no effect.
- IDLE, i_step pulse three times, 4 cycles apart -> exactly 3 cycles with o_pipe_en=1, o_cycle_cnt=3, state back to IDLE.
- RUN, i_halt_req=1 at the same cycle as an ECALL in ID -> no enables that cycle, state IDLE, o_done=0. Later i_start resumes RUN, and the ECALL then triggers DRAIN.
